// File: rtl/amoled_wave_pkg.sv
// ---------------------------------------------------------------------------
// amoled_wave_pkg
//   Shared definitions for the AMOLED frame sequencer:
//   - phase_e      : state / phase encoding, also driven out on the phase port
//   - DRIVE_TBL    : logical drive pattern {vinit,vcomp,vscan,vem1,vem2} per phase
//   - next_segment : first non-empty frame segment after a given one
// ---------------------------------------------------------------------------
package amoled_wave_pkg;

   localparam int PHASE_W = 3;
   localparam int DRIVE_W = 5;

   typedef enum logic [PHASE_W-1:0] {
      PH_IDLE = 3'd0,
      PH_INIT = 3'd1,
      PH_SCAN = 3'd2,
      PH_EMIT = 3'd3,
      PH_HOLD = 3'd4,
      PH_TAIL = 3'd5,
      PH_DEAD = 3'd6
   } phase_e;

   // Indexed by phase code; entry 7 is unused and kept all-off.
   // Bit order {vinit,vcomp,vscan,vem1,vem2}. vscan and vem1 are never both set.
   localparam logic [7:0][DRIVE_W-1:0] DRIVE_TBL = {
      5'b00000,   // 7 unused
      5'b00000,   // 6 DEAD
      5'b00010,   // 5 TAIL
      5'b01011,   // 4 HOLD
      5'b00011,   // 3 EMIT
      5'b01100,   // 2 SCAN
      5'b11000,   // 1 INIT
      5'b00000    // 0 IDLE
   };

   // nz[k] flags a non-zero duration for phase code k+1 (INIT..TAIL).
   // Returns the lowest-coded non-empty segment after 'cur', or PH_IDLE when
   // the frame has nothing left. Called with PH_IDLE to find a frame's first segment.
   function automatic phase_e next_segment(phase_e cur, logic [4:0] nz);
      phase_e nxt;
      nxt = PH_IDLE;
      for (int p = int'(PH_TAIL); p >= int'(PH_INIT); p--) begin
         if (p > int'(cur) && nz[p-1]) nxt = phase_e'(p);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/amoled_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// amoled_frame_sequencer_if
//   Bundle between the panel timing controller and the frame sequencer.
//   Controller -> sequencer : start, stop, cont, cfg_t_* durations
//   Sequencer -> drivers    : vinit, vcomp, vscan, vem1, vem2, row_sel, phase,
//                             busy, frame_done
//   master = timing controller side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface amoled_frame_sequencer_if
   import amoled_wave_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int ROWS  = 4
);
   logic               start;
   logic               stop;
   logic               cont;
   logic [CNT_W-1:0]   cfg_t_init;
   logic [CNT_W-1:0]   cfg_t_scan;
   logic [CNT_W-1:0]   cfg_t_emit;
   logic [CNT_W-1:0]   cfg_t_hold;
   logic [CNT_W-1:0]   cfg_t_tail;

   logic               vinit;
   logic               vcomp;
   logic               vscan;
   logic               vem1;
   logic               vem2;
   logic [ROWS-1:0]    row_sel;
   logic [PHASE_W-1:0] phase;
   logic               busy;
   logic               frame_done;

   modport master (
      output start, stop, cont,
      output cfg_t_init, cfg_t_scan, cfg_t_emit, cfg_t_hold, cfg_t_tail,
      input  vinit, vcomp, vscan, vem1, vem2, row_sel, phase, busy, frame_done
   );

   modport slave (
      input  start, stop, cont,
      input  cfg_t_init, cfg_t_scan, cfg_t_emit, cfg_t_hold, cfg_t_tail,
      output vinit, vcomp, vscan, vem1, vem2, row_sel, phase, busy, frame_done
   );
endinterface

// File: rtl/amoled_phase_timer.sv
// ---------------------------------------------------------------------------
// amoled_phase_timer
//   Down-counter shared by every frame segment and dead-time gap.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (segment length minus one)
//   load_val   : value loaded on 'load'
//   en         : count down while set; holds at zero, never wraps
//   last       : counter is zero, i.e. current cycle is the segment's last
// ---------------------------------------------------------------------------
module amoled_phase_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             last
);

   logic [CNT_W-1:0] cnt;

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values, independent of statement or process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign last = (cnt == '0);

endmodule

// File: rtl/amoled_frame_sequencer.sv
// ---------------------------------------------------------------------------
// amoled_frame_sequencer
//   Sequences one AMOLED frame: INIT, SCAN row 0..ROWS-1, EMIT, HOLD, TAIL,
//   with DEAD all-off gaps between consecutive non-empty segments. Durations
//   are shadowed at every frame launch; cont=1 chains frames back to back.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : slave side of amoled_frame_sequencer_if (controls in, drives out)
// ---------------------------------------------------------------------------
module amoled_frame_sequencer
   import amoled_wave_pkg::*;
#(
   parameter int CNT_W      = 16,
   parameter int ROWS       = 4,
   parameter int DEAD       = 2,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   amoled_frame_sequencer_if.slave bus
);

   localparam int               ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD = (DEAD > 0) ? CNT_W'(DEAD - 1) : '0;

   phase_e             state, state_n;
   phase_e             tgt, tgt_n;       // segment entered when a DEAD gap ends
   phase_e             first_raw, nxt;
   logic [ROW_W-1:0]   row, row_n;
   logic               stop_latch, stop_n;
   logic               pend, pend_n;     // empty frame in cont mode: relaunch next cycle
   logic               launch, shadow_ld, done_n;
   logic               load, last;
   logic [CNT_W-1:0]   load_val;
   logic [CNT_W-1:0]   sh_init, sh_scan, sh_emit, sh_hold, sh_tail;
   logic [4:0]         nz_raw, nz_sh;

   logic [DRIVE_W-1:0] drive_q;
   logic [ROWS-1:0]    row_sel_q;
   logic               busy_q, done_q;

   function automatic logic [CNT_W-1:0] seg_len(
      phase_e p, logic [CNT_W-1:0] ti, ts, te, th, tt);
      logic [CNT_W-1:0] len;
      case (p)
         PH_INIT: len = ti;
         PH_SCAN: len = ts;
         PH_EMIT: len = te;
         PH_HOLD: len = th;
         PH_TAIL: len = tt;
         default: len = '0;
      endcase
      return len;
   endfunction

   amoled_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .en       (state != PH_IDLE),
      .last     (last)
   );

   assign nz_raw = {bus.cfg_t_tail != '0, bus.cfg_t_hold != '0, bus.cfg_t_emit != '0,
                    bus.cfg_t_scan != '0, bus.cfg_t_init != '0};
   assign nz_sh  = {sh_tail != '0, sh_hold != '0, sh_emit != '0,
                    sh_scan != '0, sh_init != '0};

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_n   = state;
      tgt_n     = tgt;
      row_n     = row;
      load      = 1'b0;
      load_val  = '0;
      shadow_ld = 1'b0;
      done_n    = 1'b0;
      pend_n    = 1'b0;
      launch    = 1'b0;
      nxt       = PH_IDLE;
      stop_n    = stop_latch | (bus.stop && state != PH_IDLE);
      first_raw = next_segment(PH_IDLE, nz_raw);

      case (state)
         PH_IDLE: begin
            stop_n = 1'b0;
            if (bus.start || pend) launch = 1'b1;
         end
         PH_DEAD: begin
            if (last) begin
               state_n  = tgt;
               load     = 1'b1;
               load_val = seg_len(tgt, sh_init, sh_scan, sh_emit, sh_hold, sh_tail) - 1'b1;
            end
         end
         default: begin
            if (last) begin
               if (state == PH_SCAN && row != ROW_LAST) nxt = PH_SCAN;
               else                                     nxt = next_segment(state, nz_sh);

               if (nxt != PH_IDLE) begin
                  if (state == PH_SCAN && nxt == PH_SCAN) row_n = row + 1'b1;
                  load = 1'b1;
                  if (DEAD > 0) begin
                     state_n  = PH_DEAD;
                     tgt_n    = nxt;
                     load_val = DEAD_LOAD;
                  end else begin
                     state_n  = nxt;
                     load_val = seg_len(nxt, sh_init, sh_scan, sh_emit, sh_hold, sh_tail) - 1'b1;
                  end
               end else begin
                  // Frame end: a stop seen on this very edge also blocks the restart.
                  done_n = 1'b1;
                  stop_n = 1'b0;
                  if (bus.cont && !(stop_latch || bus.stop)) launch = 1'b1;
                  else                                       state_n = PH_IDLE;
               end
            end
         end
      endcase

      // A launch starts straight into the first non-empty segment (no dead time)
      // using the live cfg values, which are captured into the shadows alongside.
      if (launch) begin
         shadow_ld = 1'b1;
         row_n     = '0;
         state_n   = first_raw;
         if (first_raw == PH_IDLE) begin
            done_n = 1'b1;
            pend_n = bus.cont && !bus.stop;
         end else begin
            load     = 1'b1;
            load_val = seg_len(first_raw, bus.cfg_t_init, bus.cfg_t_scan, bus.cfg_t_emit,
                               bus.cfg_t_hold, bus.cfg_t_tail) - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= PH_IDLE;
         tgt        <= PH_IDLE;
         row        <= '0;
         stop_latch <= 1'b0;
         pend       <= 1'b0;
         sh_init    <= '0;
         sh_scan    <= '0;
         sh_emit    <= '0;
         sh_hold    <= '0;
         sh_tail    <= '0;
         drive_q    <= {DRIVE_W{ACTIVE_LOW}};
         row_sel_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state      <= state_n;
         tgt        <= tgt_n;
         row        <= row_n;
         stop_latch <= stop_n;
         pend       <= pend_n;
         if (shadow_ld) begin
            sh_init <= bus.cfg_t_init;
            sh_scan <= bus.cfg_t_scan;
            sh_emit <= bus.cfg_t_emit;
            sh_hold <= bus.cfg_t_hold;
            sh_tail <= bus.cfg_t_tail;
         end
         // Outputs are decoded from the next state so they line up with 'state'.
         drive_q    <= DRIVE_TBL[state_n] ^ {DRIVE_W{ACTIVE_LOW}};
         row_sel_q  <= (state_n == PH_SCAN) ? (ROWS'(1) << row_n) : '0;
         busy_q     <= (state_n != PH_IDLE);
         done_q     <= done_n;
      end
   end

   assign bus.vinit      = drive_q[4];
   assign bus.vcomp      = drive_q[3];
   assign bus.vscan      = drive_q[2];
   assign bus.vem1       = drive_q[1];
   assign bus.vem2       = drive_q[0];
   assign bus.row_sel    = row_sel_q;
   assign bus.phase      = state;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_amoled_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_amoled_frame_sequencer
//   Two sequencer instances: 'dut' (ROWS=4, DEAD=2, active-high drives) and
//   'dut_al' (ROWS=4, DEAD=0, ACTIVE_LOW=1). Expected per-cycle outputs are
//   generated from the frame description and queued as stimulus is applied,
//   then popped and compared one record per clock.
// ---------------------------------------------------------------------------
module tb_amoled_frame_sequencer;

   localparam int CNT_W = 16;
   localparam int ROWS  = 4;

   localparam logic [2:0] P_IDLE = 3'd0, P_INIT = 3'd1, P_SCAN = 3'd2, P_EMIT = 3'd3,
                          P_HOLD = 3'd4, P_TAIL = 3'd5, P_DEAD = 3'd6;
   localparam logic [4:0] D_INIT = 5'b11000, D_SCAN = 5'b01100, D_EMIT = 5'b00011,
                          D_HOLD = 5'b01011, D_TAIL = 5'b00010;

   typedef struct packed {
      logic [2:0] ph;
      logic [4:0] drv;
      logic [3:0] rs;
      logic       busy;
      logic       done;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   amoled_frame_sequencer_if #(.CNT_W(CNT_W), .ROWS(ROWS)) ifa ();
   amoled_frame_sequencer_if #(.CNT_W(CNT_W), .ROWS(ROWS)) ifb ();

   amoled_frame_sequencer #(.CNT_W(CNT_W), .ROWS(ROWS), .DEAD(2), .ACTIVE_LOW(1'b0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   amoled_frame_sequencer #(.CNT_W(CNT_W), .ROWS(ROWS), .DEAD(0), .ACTIVE_LOW(1'b1)) dut_al (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   obs_t q[$];
   int   n_cmp = 0;
   int   n_mis = 0;
   bit   done_carry = 1'b0;

   function automatic obs_t grab_obs(input bit b);
      obs_t o;
      if (!b) o = {ifa.phase, ifa.vinit, ifa.vcomp, ifa.vscan, ifa.vem1, ifa.vem2,
                   ifa.row_sel, ifa.busy, ifa.frame_done};
      else    o = {ifb.phase, ifb.vinit, ifb.vcomp, ifb.vscan, ifb.vem1, ifb.vem2,
                   ifb.row_sel, ifb.busy, ifb.frame_done};
      return o;
   endfunction

   task automatic push_cyc(input logic [2:0] ph, input logic [4:0] drv,
                           input logic [3:0] rs, input logic bz);
      obs_t e;
      e.ph = ph; e.drv = drv; e.rs = rs; e.busy = bz; e.done = done_carry;
      done_carry = 1'b0;
      q.push_back(e);
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) push_cyc(P_IDLE, 5'b0, 4'b0, 1'b0);
   endtask

   // Expected waveform of one frame; the following record carries frame_done.
   task automatic model_frame(input int ti, ts, te, th, tt, input int dead);
      logic [2:0] sph [8];
      logic [4:0] sdrv[8];
      logic [3:0] srs [8];
      int         slen[8];
      int         nseg;
      nseg = 0;
      if (ti > 0) begin sph[nseg] = P_INIT; sdrv[nseg] = D_INIT; srs[nseg] = 4'b0; slen[nseg] = ti; nseg++; end
      if (ts > 0) for (int r = 0; r < ROWS; r++) begin
         sph[nseg] = P_SCAN; sdrv[nseg] = D_SCAN; srs[nseg] = 4'(1 << r); slen[nseg] = ts; nseg++;
      end
      if (te > 0) begin sph[nseg] = P_EMIT; sdrv[nseg] = D_EMIT; srs[nseg] = 4'b0; slen[nseg] = te; nseg++; end
      if (th > 0) begin sph[nseg] = P_HOLD; sdrv[nseg] = D_HOLD; srs[nseg] = 4'b0; slen[nseg] = th; nseg++; end
      if (tt > 0) begin sph[nseg] = P_TAIL; sdrv[nseg] = D_TAIL; srs[nseg] = 4'b0; slen[nseg] = tt; nseg++; end
      for (int i = 0; i < nseg; i++) begin
         if (i > 0) for (int d = 0; d < dead; d++) push_cyc(P_DEAD, 5'b0, 4'b0, 1'b1);
         for (int c = 0; c < slen[i]; c++) push_cyc(sph[i], sdrv[i], srs[i], 1'b1);
      end
      done_carry = 1'b1;
   endtask

   task automatic set_cfg_a(input int ti, ts, te, th, tt);
      ifa.cfg_t_init = CNT_W'(ti); ifa.cfg_t_scan = CNT_W'(ts); ifa.cfg_t_emit = CNT_W'(te);
      ifa.cfg_t_hold = CNT_W'(th); ifa.cfg_t_tail = CNT_W'(tt);
   endtask

   task automatic test_reset();
      obs_t e, o;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      e = '0;
      o = grab_obs(1'b0);
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL reset_state_a got %b want %b", o, e); end
      e.drv = 5'b11111;
      o = grab_obs(1'b1);
      n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL reset_state_al got %b want %b", o, e); end
      reset = 1'b0;
   endtask

   // One frame, cont=0; a start pulse while busy must be ignored.
   task automatic test_single_frame();
      obs_t e, o;
      int idx;
      @(negedge clk);
      set_cfg_a(5, 3, 10, 4, 2);
      ifa.cont = 1'b0; ifa.start = 1'b1;
      model_frame(5, 3, 10, 4, 2, 2);
      push_idle(3);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL single_frame idx %0d got %b want %b", idx, o, e); end
         if (idx == 0)  ifa.start = 1'b0;
         if (idx == 20) ifa.start = 1'b1;
         if (idx == 21) ifa.start = 1'b0;
         idx++;
      end
   endtask

   // cont=1: frame 2 follows frame 1 with no gap; stop during frame 2 EMIT ends the run.
   task automatic test_cont_stop();
      obs_t e, o;
      int idx;
      @(negedge clk);
      set_cfg_a(5, 3, 10, 4, 2);
      ifa.cont = 1'b1; ifa.start = 1'b1;
      model_frame(5, 3, 10, 4, 2, 2);
      model_frame(5, 3, 10, 4, 2, 2);
      push_idle(3);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL cont_stop idx %0d got %b want %b", idx, o, e); end
         if (idx == 0)  ifa.start = 1'b0;
         if (idx == 77) ifa.stop  = 1'b1;
         if (idx == 78) ifa.stop  = 1'b0;
         idx++;
      end
      ifa.cont = 1'b0;
   endtask

   // Zero scan/hold: no rows, INIT-DEAD-EMIT-DEAD-TAIL. stop with start in IDLE is ignored.
   task automatic test_skip_phases();
      obs_t e, o;
      int idx;
      @(negedge clk);
      set_cfg_a(5, 0, 10, 0, 2);
      ifa.cont = 1'b1; ifa.start = 1'b1; ifa.stop = 1'b1;
      model_frame(5, 0, 10, 0, 2, 2);
      model_frame(5, 0, 10, 0, 2, 2);
      push_idle(2);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL skip_phases idx %0d got %b want %b", idx, o, e); end
         if (idx == 0)  begin ifa.start = 1'b0; ifa.stop = 1'b0; end
         if (idx == 29) ifa.stop = 1'b1;
         if (idx == 30) ifa.stop = 1'b0;
         idx++;
      end
      ifa.cont = 1'b0;
   endtask

   // cfg changes mid-frame only take effect at the next frame launch.
   task automatic test_cfg_shadow();
      obs_t e, o;
      int idx;
      @(negedge clk);
      set_cfg_a(5, 3, 10, 4, 2);
      ifa.cont = 1'b1; ifa.start = 1'b1;
      model_frame(5, 3, 10, 4, 2, 2);
      model_frame(5, 3, 20, 4, 2, 2);
      push_idle(2);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL cfg_shadow idx %0d got %b want %b", idx, o, e); end
         if (idx == 0)  ifa.start = 1'b0;
         if (idx == 30) ifa.cfg_t_emit = CNT_W'(20);
         if (idx == 50) ifa.cfg_t_hold = CNT_W'(9);
         if (idx == 60) ifa.stop = 1'b1;
         if (idx == 61) ifa.stop = 1'b0;
         idx++;
      end
      ifa.cont = 1'b0;
      set_cfg_a(5, 3, 10, 4, 2);
   endtask

   // Reset during SCAN row 2 (with a stop latched); then a clean cont run must restart.
   task automatic test_reset_mid();
      obs_t e, o;
      int idx;
      @(negedge clk);
      set_cfg_a(5, 3, 10, 4, 2);
      ifa.cont = 1'b1; ifa.start = 1'b1;
      model_frame(5, 3, 10, 4, 2, 2);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL reset_mid idx %0d got %b want %b", idx, o, e); end
         if (idx == 0)  ifa.start = 1'b0;
         if (idx == 10) ifa.stop = 1'b1;
         if (idx == 11) ifa.stop = 1'b0;
         if (idx == 18) begin
            reset = 1'b1;
            q.delete();
            done_carry = 1'b0;
            push_idle(1);
         end
         if (idx == 19) reset = 1'b0;
         idx++;
      end

      @(negedge clk);
      ifa.start = 1'b1;
      model_frame(5, 3, 10, 4, 2, 2);
      model_frame(5, 3, 10, 4, 2, 2);
      push_idle(2);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL after_reset idx %0d got %b want %b", idx, o, e); end
         if (idx == 0)  ifa.start = 1'b0;
         if (idx == 77) ifa.stop = 1'b1;
         if (idx == 78) ifa.stop = 1'b0;
         idx++;
      end
      ifa.cont = 1'b0;
   endtask

   // All durations zero: accepted, frame_done the next cycle with busy low.
   task automatic test_zero_all();
      obs_t e, o;
      int idx;
      @(negedge clk);
      set_cfg_a(0, 0, 0, 0, 0);
      ifa.cont = 1'b0; ifa.start = 1'b1;
      done_carry = 1'b1;
      push_idle(3);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front(); o = grab_obs(1'b0);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL zero_all idx %0d got %b want %b", idx, o, e); end
         if (idx == 0) ifa.start = 1'b0;
         idx++;
      end
   endtask

   // ACTIVE_LOW=1, DEAD=0, all durations 1: 8-cycle frame, drives inverted, idle level high.
   task automatic test_active_low();
      obs_t e, o;
      int idx;
      @(negedge clk);
      ifb.cfg_t_init = CNT_W'(1); ifb.cfg_t_scan = CNT_W'(1); ifb.cfg_t_emit = CNT_W'(1);
      ifb.cfg_t_hold = CNT_W'(1); ifb.cfg_t_tail = CNT_W'(1);
      ifb.cont = 1'b0; ifb.start = 1'b1;
      model_frame(1, 1, 1, 1, 1, 0);
      push_idle(2);
      idx = 0;
      while (q.size() > 0) begin
         @(posedge clk); #1;
         e = q.pop_front();
         e.drv = e.drv ^ 5'b11111;
         o = grab_obs(1'b1);
         n_cmp++;
         if (o !== e) begin n_mis++; $display("FAIL active_low idx %0d got %b want %b", idx, o, e); end
         if (idx == 0) ifb.start = 1'b0;
         idx++;
      end
   endtask

   initial begin
      ifa.start = 1'b0; ifa.stop = 1'b0; ifa.cont = 1'b0;
      ifb.start = 1'b0; ifb.stop = 1'b0; ifb.cont = 1'b0;
      set_cfg_a(0, 0, 0, 0, 0);
      ifb.cfg_t_init = '0; ifb.cfg_t_scan = '0; ifb.cfg_t_emit = '0;
      ifb.cfg_t_hold = '0; ifb.cfg_t_tail = '0;

      test_reset();
      test_single_frame();
      test_cont_stop();
      test_skip_phases();
      test_cfg_shadow();
      test_reset_mid();
      test_zero_all();
      test_active_low();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
